// File: rtl/escape_dec_pkg.sv
// Shared types and opcode constants for the opcode-stage escape decoder.
// Record fields whose width depends on module parameters live outside rec_t.
package escape_dec_pkg;

    typedef enum logic [2:0] {
        K_OTHER  = 3'd0,
        K_JCC    = 3'd1,
        K_NOP    = 3'd2,
        K_IGNORE = 3'd3,
        K_UNSUP  = 3'd4,
        K_FAULT  = 3'd5
    } kind_t;

    typedef enum logic [2:0] {
        IDLE,
        ESC,
        ESC3,
        DISP,
        EMIT
    } state_t;

    localparam logic [7:0] OP_ESC        = 8'h0F;
    localparam logic [7:0] OP_ESC38      = 8'h38;
    localparam logic [7:0] OP_ESC3A      = 8'h3A;
    localparam logic [7:0] OP_NOP_RM     = 8'h1F;
    localparam logic [7:0] OP_JCC8_BASE  = 8'h70;
    localparam logic [7:0] OP_JCC32_BASE = 8'h80;
    localparam logic [7:0] OP_PUSH_FS    = 8'hA0;
    localparam logic [7:0] OP_POP_FS     = 8'hA1;
    localparam logic [7:0] OP_PUSH_GS    = 8'hA8;
    localparam logic [7:0] OP_POP_GS     = 8'hA9;

    typedef struct packed {
        kind_t      kind;
        logic [3:0] cond;
        logic [7:0] opcode;
        logic       need_modrm;
        logic       rex_w;
    } rec_t;

    // True when b lies in the 16-entry opcode row starting at base.
    function automatic logic in_row(input logic [7:0] b, input logic [7:0] base);
        return (b & 8'hF0) == base;
    endfunction

endpackage

// File: rtl/disp_accumulator.sv
// Collects a little-endian Jcc displacement (1 or 4 bytes) and produces the
// branch target for the byte currently being accepted.
module disp_accumulator #(
    parameter int ADDR_W = 64,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              shift_en,
    input  logic              wide,
    input  logic [7:0]        data,
    input  logic [ADDR_W-1:0] base_pc,
    input  logic [LEN_W-1:0]  len_next,
    output logic              last,
    output logic [ADDR_W-1:0] target
);

    logic [23:0]       disp_q;
    logic [2:0]        count_q;
    logic [31:0]       disp_next;
    logic [ADDR_W-1:0] disp_sext;

    // The incoming byte is always the most significant one seen so far, so the
    // target is formed from it directly without waiting for it to be stored.
    assign disp_next = {data, disp_q};
    assign last      = (count_q + 3'd1) == (wide ? 3'd4 : 3'd1);
    assign disp_sext = wide ? ADDR_W'($signed(disp_next)) : ADDR_W'($signed(data));
    assign target    = base_pc + ADDR_W'(len_next) + disp_sext;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            disp_q  <= '0;
            count_q <= '0;
        end else if (shift_en) begin
            disp_q  <= disp_next[31:8];
            count_q <= count_q + 3'd1;
        end
    end

endmodule

// File: rtl/escape_opcode_decoder.sv
// Byte-serial opcode decoder: resolves one-byte Jcc, the 0x0F map and the
// 0x0F 0x38/0x3A escapes, and emits one registered record per instruction.
module escape_opcode_decoder
    import escape_dec_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int MAX_LEN = 15,
    parameter int LEN_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic [3:0]        in_rex,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        out_kind,
    output logic [3:0]        out_cond,
    output logic [ADDR_W-1:0] out_target,
    output logic [LEN_W-1:0]  out_len,
    output logic [7:0]        out_opcode,
    output logic              out_need_modrm,
    output logic              out_rex_w
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, target_q, target_d, acc_target;
    logic [LEN_W-1:0]  len_q, len_d, len_inc, len_out_q, len_out_d;
    logic              wide_q, wide_d;
    rec_t              cur_q, cur_d, rec_q, rec_d;
    logic              accept, at_limit, disp_clear, disp_shift, disp_last;
    logic              unused_rex;

    assign in_ready   = (state_q != EMIT);
    assign accept     = in_valid && in_ready;
    assign len_inc    = len_q + LEN_W'(1);
    assign at_limit   = (len_q == LEN_W'(MAX_LEN));
    assign unused_rex = ^in_rex[2:0];

    disp_accumulator #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_disp (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush || disp_clear),
        .shift_en (disp_shift),
        .wide     (wide_q),
        .data     (in_byte),
        .base_pc  (pc_q),
        .len_next (len_inc),
        .last     (disp_last),
        .target   (acc_target)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        len_d      = len_q;
        wide_d     = wide_q;
        cur_d      = cur_q;
        rec_d      = rec_q;
        len_out_d  = len_out_q;
        target_d   = target_q;
        disp_clear = 1'b0;
        disp_shift = 1'b0;

        unique case (state_q)
            IDLE: if (accept) begin
                pc_d  = in_pc;
                len_d = LEN_W'(1);
                cur_d = '{kind: K_OTHER, cond: 4'd0, opcode: in_byte,
                          need_modrm: 1'b0, rex_w: in_rex[3]};
                if (in_byte == OP_ESC) begin
                    state_d = ESC;
                end else if (in_row(in_byte, OP_JCC8_BASE)) begin
                    cur_d.kind = K_JCC;
                    cur_d.cond = in_byte[3:0];
                    wide_d     = 1'b0;
                    disp_clear = 1'b1;
                    state_d    = DISP;
                end else begin
                    state_d = EMIT;
                end
            end
            ESC: if (accept) begin
                len_d        = len_inc;
                cur_d.opcode = in_byte;
                if (in_row(in_byte, OP_JCC32_BASE)) begin
                    cur_d.kind = K_JCC;
                    cur_d.cond = in_byte[3:0];
                    wide_d     = 1'b1;
                    disp_clear = 1'b1;
                    state_d    = DISP;
                end else begin
                    case (in_byte)
                        OP_NOP_RM: begin
                            cur_d.kind       = K_NOP;
                            cur_d.need_modrm = 1'b1;
                            state_d          = EMIT;
                        end
                        OP_PUSH_FS, OP_POP_FS, OP_PUSH_GS, OP_POP_GS: begin
                            cur_d.kind = K_IGNORE;
                            state_d    = EMIT;
                        end
                        OP_ESC38, OP_ESC3A: state_d = ESC3;
                        default: begin
                            cur_d.kind = K_UNSUP;
                            state_d    = EMIT;
                        end
                    endcase
                end
            end
            ESC3: if (accept) begin
                len_d            = len_inc;
                cur_d.kind       = K_UNSUP;
                cur_d.opcode     = in_byte;
                cur_d.need_modrm = 1'b1;
                state_d          = EMIT;
            end
            DISP: if (accept) begin
                len_d      = len_inc;
                disp_shift = 1'b1;
                if (disp_last) state_d = EMIT;
            end
            EMIT: if (out_ready) begin
                state_d   = IDLE;
                rec_d     = '0;
                len_out_d = '0;
                target_d  = '0;
            end
            default: state_d = IDLE;
        endcase

        // Length guard: keep the length reached so far and report a fault.
        if (accept && at_limit && (state_q != IDLE)) begin
            cur_d            = cur_q;
            cur_d.kind       = K_FAULT;
            cur_d.cond       = 4'd0;
            cur_d.need_modrm = 1'b0;
            len_d            = len_q;
            disp_shift       = 1'b0;
            state_d          = EMIT;
        end

        if ((state_q != EMIT) && (state_d == EMIT)) begin
            rec_d     = cur_d;
            len_out_d = len_d;
            target_d  = (cur_d.kind == K_JCC) ? acc_target : '0;
        end
    end

    // Flush shares the reset path: it abandons any partial instruction or
    // pending record in one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            len_q     <= '0;
            wide_q    <= 1'b0;
            cur_q     <= '0;
            rec_q     <= '0;
            len_out_q <= '0;
            target_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            len_q     <= len_d;
            wide_q    <= wide_d;
            cur_q     <= cur_d;
            rec_q     <= rec_d;
            len_out_q <= len_out_d;
            target_q  <= target_d;
        end
    end

    assign out_valid      = (state_q == EMIT);
    assign out_kind       = rec_q.kind;
    assign out_cond       = rec_q.cond;
    assign out_target     = target_q;
    assign out_len        = len_out_q;
    assign out_opcode     = rec_q.opcode;
    assign out_need_modrm = rec_q.need_modrm;
    assign out_rex_w      = rec_q.rex_w;

endmodule
